// File: rtl/cpsr_flag_unit_if.sv
// -----------------------------------------------------------------------------
// cpsr_flag_unit_if
//
// Purpose: bundles the Execute-stage signals exchanged between the pipeline
// and the CPSR flag unit. The pipeline side uses the master modport and the
// flag unit uses the slave modport.
//
// Signals (direction given from the flag unit's point of view):
//   StallE            in   1   Execute stage held; no state change
//   FlushE            in   1   Execute instruction squashed
//   CondE             in   4   ARM condition field of the Execute instruction
//   FlagWriteE        in   2   [1] updates N,Z ; [0] updates C,V
//   CVUpdateE         in   3   C/V source select from the ALU decoder
//   ALUResultE        in  32   ALU result
//   ALUCarryOutE      in   1   adder carry out
//   ALUOverflowE      in   1   adder overflow
//   ShifterCarryOutE  in   1   barrel shifter carry out
//   CPSRWriteE        in   1   MSR-style direct flag write
//   CPSRDataE         in   4   NZCV value for CPSRWriteE
//   MicroOpStartE     in   1   first micro-op of a sequence
//   MicroOpLastE      in   1   last micro-op of a sequence
//   FlagsQ            out  4   committed architectural NZCV
//   PreviousCVFlag    out  2   {C,V} of the visible flags
//   CondExE           out  1   Execute instruction passes its condition
//   SeqActive         out  1   unit is inside a micro-op sequence
//   SeqErr            out  1   one-cycle protocol-error pulse
// -----------------------------------------------------------------------------
interface cpsr_flag_unit_if;
    logic        StallE;
    logic        FlushE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [2:0]  CVUpdateE;
    logic [31:0] ALUResultE;
    logic        ALUCarryOutE;
    logic        ALUOverflowE;
    logic        ShifterCarryOutE;
    logic        CPSRWriteE;
    logic [3:0]  CPSRDataE;
    logic        MicroOpStartE;
    logic        MicroOpLastE;
    logic [3:0]  FlagsQ;
    logic [1:0]  PreviousCVFlag;
    logic        CondExE;
    logic        SeqActive;
    logic        SeqErr;

    // Pipeline side: drives Execute-stage controls, observes flag state.
    modport master (
        output StallE, FlushE, CondE, FlagWriteE, CVUpdateE, ALUResultE,
               ALUCarryOutE, ALUOverflowE, ShifterCarryOutE,
               CPSRWriteE, CPSRDataE, MicroOpStartE, MicroOpLastE,
        input  FlagsQ, PreviousCVFlag, CondExE, SeqActive, SeqErr
    );

    // Flag unit side.
    modport slave (
        input  StallE, FlushE, CondE, FlagWriteE, CVUpdateE, ALUResultE,
               ALUCarryOutE, ALUOverflowE, ShifterCarryOutE,
               CPSRWriteE, CPSRDataE, MicroOpStartE, MicroOpLastE,
        output FlagsQ, PreviousCVFlag, CondExE, SeqActive, SeqErr
    );
endinterface

// File: rtl/cpsr_flag_unit.sv
// -----------------------------------------------------------------------------
// cpsr_flag_unit
//
// Purpose: holds the architectural NZCV flags, evaluates the ARM condition
// field of the Execute-stage instruction, and applies flag updates from the
// ALU or from an MSR-style direct write. Multi-cycle micro-op sequences build
// their flag result in a shadow register and commit it to FlagsQ only when the
// Last micro-op retires, so a flushed sequence leaves FlagsQ untouched.
//
// Ports:
//   clk      in   single clock, all state changes on the rising edge
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of cpsr_flag_unit_if (see that file for signals)
//
// Flag vector layout everywhere: [3]=N [2]=Z [1]=C [0]=V.
// -----------------------------------------------------------------------------
module cpsr_flag_unit (
    input  logic           clk,
    input  logic           reset_n,
    cpsr_flag_unit_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // ARMv4 condition decode against a given flag set.
    function automatic logic cond_pass(input logic [3:0] cond, input nzcv_t f);
        logic pass;
        pass = 1'b0;
        case (cond)
            4'b0000: pass = f.z;                         // EQ
            4'b0001: pass = !f.z;                        // NE
            4'b0010: pass = f.c;                         // CS/HS
            4'b0011: pass = !f.c;                        // CC/LO
            4'b0100: pass = f.n;                         // MI
            4'b0101: pass = !f.n;                        // PL
            4'b0110: pass = f.v;                         // VS
            4'b0111: pass = !f.v;                        // VC
            4'b1000: pass = f.c && !f.z;                 // HI
            4'b1001: pass = !f.c || f.z;                 // LS
            4'b1010: pass = (f.n == f.v);                // GE
            4'b1011: pass = (f.n != f.v);                // LT
            4'b1100: pass = !f.z && (f.n == f.v);        // GT
            4'b1101: pass = f.z || (f.n != f.v);         // LE
            4'b1110: pass = 1'b1;                        // AL
            4'b1111: pass = 1'b0;                        // NV
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Registered state
    seq_state_t state_q,  state_d;
    nzcv_t      flags_q,  flags_d;
    nzcv_t      shadow_q, shadow_d;
    logic       seq_err_q, seq_err_d;

    // Combinational helpers
    nzcv_t visible;     // flags the Execute instruction sees
    nzcv_t upd;         // visible flags with this instruction's write applied
    nzcv_t applied;     // upd if accepted, otherwise visible unchanged
    logic  cond_ex;
    logic  advance;     // neither stalled nor flushed
    logic  accept;      // advance and condition passes

    // CVUpdateE[0] carries no meaning for the flag unit.
    logic  unused_cvu0;
    assign unused_cvu0 = bus.CVUpdateE[0];

    // -------------------------------------------------------------------------
    // Flag update datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves a variable unassigned, which would infer a latch.
        visible = (state_q == SEQ) ? shadow_q : flags_q;
        cond_ex = cond_pass(bus.CondE, visible);
        advance = !bus.StallE && !bus.FlushE;
        accept  = advance && cond_ex;

        upd = visible;
        if (bus.CPSRWriteE) begin
            // A direct write replaces all four flags and overrides the S-bit.
            upd = nzcv_t'(bus.CPSRDataE);
        end else begin
            if (bus.FlagWriteE[1]) begin
                upd.n = bus.ALUResultE[31];
                upd.z = (bus.ALUResultE == 32'd0);
            end
            if (bus.FlagWriteE[0]) begin
                if (bus.CVUpdateE[2]) begin
                    // Arithmetic: adder carry; V from adder unless KeepV.
                    upd.c = bus.ALUCarryOutE;
                    if (!bus.CVUpdateE[1]) begin
                        upd.v = bus.ALUOverflowE;
                    end
                end else begin
                    // Logical: shifter carry, V untouched.
                    upd.c = bus.ShifterCarryOutE;
                end
            end
        end

        applied = accept ? upd : visible;
    end

    // -------------------------------------------------------------------------
    // Sequence FSM: next state and next register values
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        shadow_d  = shadow_q;
        seq_err_d = 1'b0;

        if (bus.FlushE) begin
            // Flush beats stall: the squashed sequence is abandoned.
            state_d  = IDLE;
            shadow_d = '0;
        end else if (!bus.StallE) begin
            case (state_q)
                IDLE: begin
                    if (accept && bus.MicroOpStartE && !bus.MicroOpLastE) begin
                        state_d  = SEQ;
                        shadow_d = applied;
                    end else begin
                        flags_d = applied;
                    end
                end
                SEQ: begin
                    // A stray Start is flagged but the op still continues the
                    // sequence. A condition-failed op still advances it, since
                    // applied falls back to the unchanged shadow.
                    seq_err_d = bus.MicroOpStartE;
                    if (bus.MicroOpLastE) begin
                        flags_d = applied;
                        state_d = IDLE;
                    end else begin
                        shadow_d = applied;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!reset_n) begin
            // NOTE: the shadow is a plain 4-bit register, not a memory, so it
            // is cleared with the rest of the state at no cost.
            state_q   <= IDLE;
            flags_q   <= '0;
            shadow_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            shadow_q  <= shadow_d;
            seq_err_q <= seq_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.FlagsQ         = flags_q;
    assign bus.PreviousCVFlag = {visible.c, visible.v};
    assign bus.CondExE        = cond_ex;
    assign bus.SeqActive      = (state_q == SEQ);
    assign bus.SeqErr         = seq_err_q;

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_cpsr_flag_unit
//
// Directed testbench for cpsr_flag_unit. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_cpsr_flag_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    cpsr_flag_unit_if bus ();

    cpsr_flag_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_AL = 4'b1110;

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cond, input logic [1:0] fw,
                          input logic [2:0] cvu, input logic [31:0] res,
                          input logic co, input logic ov, input logic sco);
        bus.StallE           = 1'b0;
        bus.FlushE           = 1'b0;
        bus.CondE            = cond;
        bus.FlagWriteE       = fw;
        bus.CVUpdateE        = cvu;
        bus.ALUResultE       = res;
        bus.ALUCarryOutE     = co;
        bus.ALUOverflowE     = ov;
        bus.ShifterCarryOutE = sco;
        bus.CPSRWriteE       = 1'b0;
        bus.CPSRDataE        = 4'b0000;
        bus.MicroOpStartE    = 1'b0;
        bus.MicroOpLastE     = 1'b0;
    endtask

    task automatic clear_inputs();
        set_op(C_EQ, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Direct MSR-style write of all four flags, one cycle.
    task automatic load_flags(input logic [3:0] d);
        set_op(C_AL, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.CPSRWriteE = 1'b1;
        bus.CPSRDataE  = d;
        tick();
        clear_inputs();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        total++;
        if (bus.FlagsQ !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", bus.FlagsQ);
        end
        total++;
        if (bus.SeqActive !== 1'b0 || bus.SeqErr !== 1'b0) begin
            bad++; $display("FAIL reset_seq got act=%b err=%b exp act=0 err=0", bus.SeqActive, bus.SeqErr);
        end
        total++;
        if (bus.PreviousCVFlag !== 2'b00) begin
            bad++; $display("FAIL reset_prevcv got=%b exp=00", bus.PreviousCVFlag);
        end
        bus.CondE = 4'b0001; // NE with Z=0
        #1;
        total++;
        if (bus.CondExE !== 1'b1) begin
            bad++; $display("FAIL reset_cond_ne got=%b exp=1", bus.CondExE);
        end
        reset_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_subs();
        set_op(C_AL, 2'b11, 3'b101, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        #1;
        total++; // no same-cycle bypass
        if (bus.PreviousCVFlag !== 2'b00) begin
            bad++; $display("FAIL subs_no_bypass got=%b exp=00", bus.PreviousCVFlag);
        end
        tick();
        total++;
        if (bus.FlagsQ !== 4'b0110) begin
            bad++; $display("FAIL subs_flags got=%b exp=0110", bus.FlagsQ);
        end
        total++;
        if (bus.PreviousCVFlag !== 2'b10) begin
            bad++; $display("FAIL subs_prevcv got=%b exp=10", bus.PreviousCVFlag);
        end
        clear_inputs();
        bus.CondE = C_EQ;
        #1;
        total++;
        if (bus.CondExE !== 1'b1) begin
            bad++; $display("FAIL subs_cond_eq got=%b exp=1", bus.CondExE);
        end
    endtask

    task automatic test_keepv();
        load_flags(4'b0001);
        total++;
        if (bus.FlagsQ !== 4'b0001) begin
            bad++; $display("FAIL keepv_preload got=%b exp=0001", bus.FlagsQ);
        end
        set_op(C_AL, 2'b11, 3'b110, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (bus.FlagsQ !== 4'b1001) begin
            bad++; $display("FAIL keepv_flags got=%b exp=1001", bus.FlagsQ);
        end
        // Logical op, C,V only: C from shifter, V retained, NZ retained.
        set_op(C_AL, 2'b01, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        total++;
        if (bus.FlagsQ !== 4'b1011) begin
            bad++; $display("FAIL logical_cv got=%b exp=1011", bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_cond_decode();
        logic [3:0]  flag_tab [3];
        logic [15:0] exp_tab  [3];
        logic [15:0] row;
        flag_tab[0] = 4'b0110; exp_tab[0] = 16'h66A5;
        flag_tab[1] = 4'b1010; exp_tab[1] = 16'h6996;
        flag_tab[2] = 4'b1001; exp_tab[2] = 16'h565A;
        for (int k = 0; k < 3; k++) begin
            load_flags(flag_tab[k]);
            row = exp_tab[k];
            for (int c = 0; c < 16; c++) begin
                bus.CondE = c[3:0];
                #1;
                total++;
                if (bus.CondExE !== row[c]) begin
                    bad++;
                    $display("FAIL cond_decode flags=%b cond=%b got=%b exp=%b",
                             flag_tab[k], c[3:0], bus.CondExE, row[c]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        set_op(C_AL, 2'b11, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        // EQ now sees Z=1 from the previous op.
        set_op(C_EQ, 2'b10, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (bus.CondExE !== 1'b1) begin
            bad++; $display("FAIL b2b_cond got=%b exp=1", bus.CondExE);
        end
        tick();
        total++;
        if (bus.FlagsQ !== 4'b1010) begin
            bad++; $display("FAIL b2b_flags got=%b exp=1010", bus.FlagsQ);
        end
        // EQ now fails; the direct write must be ignored.
        set_op(C_EQ, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.CPSRWriteE = 1'b1;
        bus.CPSRDataE  = 4'b0000;
        tick();
        total++;
        if (bus.FlagsQ !== 4'b1010) begin
            bad++; $display("FAIL b2b_condfail got=%b exp=1010", bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_sequence();
        load_flags(4'b0010);
        set_op(C_AL, 2'b10, 3'b000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        bus.MicroOpStartE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b1 || bus.FlagsQ !== 4'b0010) begin
            bad++; $display("FAIL seq_start got act=%b flags=%b exp act=1 flags=0010", bus.SeqActive, bus.FlagsQ);
        end
        set_op(C_AL, 2'b10, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (bus.SeqActive !== 1'b1 || bus.FlagsQ !== 4'b0010) begin
            bad++; $display("FAIL seq_mid got act=%b flags=%b exp act=1 flags=0010", bus.SeqActive, bus.FlagsQ);
        end
        // Shadow now has Z=1 while FlagsQ has Z=0: EQ must see the shadow.
        bus.CondE      = C_EQ;
        bus.FlagWriteE = 2'b00;
        #1;
        total++;
        if (bus.CondExE !== 1'b1) begin
            bad++; $display("FAIL seq_visible got=%b exp=1", bus.CondExE);
        end
        set_op(C_AL, 2'b10, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        bus.MicroOpLastE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b0 || bus.FlagsQ !== 4'b1010) begin
            bad++; $display("FAIL seq_commit got act=%b flags=%b exp act=0 flags=1010", bus.SeqActive, bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        load_flags(4'b0010);
        set_op(C_AL, 2'b11, 3'b101, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        bus.MicroOpStartE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b1 || bus.PreviousCVFlag !== 2'b01) begin
            bad++; $display("FAIL flush_start got act=%b cv=%b exp act=1 cv=01", bus.SeqActive, bus.PreviousCVFlag);
        end
        // Flush on the middle micro-op, with stall also high: flush wins.
        set_op(C_AL, 2'b11, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.FlushE = 1'b1;
        bus.StallE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b0 || bus.FlagsQ !== 4'b0010) begin
            bad++; $display("FAIL flush_mid got act=%b flags=%b exp act=0 flags=0010", bus.SeqActive, bus.FlagsQ);
        end
        total++;
        if (bus.PreviousCVFlag !== 2'b10) begin
            bad++; $display("FAIL flush_prevcv got=%b exp=10", bus.PreviousCVFlag);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        set_op(C_AL, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.StallE     = 1'b1;
        bus.CPSRWriteE = 1'b1;
        bus.CPSRDataE  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.FlagsQ !== 4'b0010) begin
                bad++; $display("FAIL stall_hold cycle=%0d got=%b exp=0010", i, bus.FlagsQ);
            end
        end
        bus.StallE = 1'b0;
        #1;
        total++;
        if (bus.FlagsQ !== 4'b0010) begin
            bad++; $display("FAIL stall_release_early got=%b exp=0010", bus.FlagsQ);
        end
        tick();
        total++;
        if (bus.FlagsQ !== 4'b1111) begin
            bad++; $display("FAIL stall_release got=%b exp=1111", bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_seq_err();
        set_op(C_AL, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.MicroOpStartE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b1 || bus.SeqErr !== 1'b0) begin
            bad++; $display("FAIL seqerr_start got act=%b err=%b exp act=1 err=0", bus.SeqActive, bus.SeqErr);
        end
        bus.StallE = 1'b1;
        tick();
        total++;
        if (bus.SeqErr !== 1'b0) begin
            bad++; $display("FAIL seqerr_stalled got=%b exp=0", bus.SeqErr);
        end
        bus.StallE = 1'b0;
        tick();
        total++;
        if (bus.SeqErr !== 1'b1 || bus.SeqActive !== 1'b1) begin
            bad++; $display("FAIL seqerr_pulse got err=%b act=%b exp err=1 act=1", bus.SeqErr, bus.SeqActive);
        end
        set_op(C_AL, 2'b10, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.MicroOpLastE = 1'b1;
        tick();
        total++;
        if (bus.SeqErr !== 1'b0 || bus.SeqActive !== 1'b0 || bus.FlagsQ !== 4'b0111) begin
            bad++; $display("FAIL seqerr_end got err=%b act=%b flags=%b exp err=0 act=0 flags=0111",
                            bus.SeqErr, bus.SeqActive, bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_cond_fail_in_seq();
        set_op(C_AL, 2'b11, 3'b101, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        bus.MicroOpStartE = 1'b1;
        tick();
        // Shadow is 0000 now; EQ fails, Last must still close the sequence.
        set_op(C_EQ, 2'b11, 3'b101, 32'h0, 1'b1, 1'b1, 1'b0);
        bus.MicroOpLastE = 1'b1;
        #1;
        total++;
        if (bus.CondExE !== 1'b0) begin
            bad++; $display("FAIL seqfail_cond got=%b exp=0", bus.CondExE);
        end
        tick();
        total++;
        if (bus.SeqActive !== 1'b0 || bus.FlagsQ !== 4'b0000) begin
            bad++; $display("FAIL seqfail_commit got act=%b flags=%b exp act=0 flags=0000", bus.SeqActive, bus.FlagsQ);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_seq();
        load_flags(4'b1111);
        set_op(C_AL, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.MicroOpStartE = 1'b1;
        tick();
        total++;
        if (bus.SeqActive !== 1'b1 || bus.FlagsQ !== 4'b1111) begin
            bad++; $display("FAIL rstseq_pre got act=%b flags=%b exp act=1 flags=1111", bus.SeqActive, bus.FlagsQ);
        end
        reset_n = 1'b0;
        bus.CPSRWriteE = 1'b1;
        bus.CPSRDataE  = 4'b0101;
        tick();
        total++;
        if (bus.FlagsQ !== 4'b0000 || bus.SeqActive !== 1'b0 || bus.SeqErr !== 1'b0) begin
            bad++; $display("FAIL rstseq_state got flags=%b act=%b err=%b exp flags=0000 act=0 err=0",
                            bus.FlagsQ, bus.SeqActive, bus.SeqErr);
        end
        bus.CPSRWriteE = 1'b0;
        bus.CondE      = C_EQ;
        #1;
        total++;
        if (bus.CondExE !== 1'b0) begin
            bad++; $display("FAIL rstseq_cond got=%b exp=0", bus.CondExE);
        end
        reset_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        clear_inputs();

        test_reset();
        test_subs();
        test_keepv();
        test_cond_decode();
        test_back_to_back();
        test_sequence();
        test_flush();
        test_stall();
        test_seq_err();
        test_cond_fail_in_seq();
        test_reset_mid_seq();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the sequencer ever stops advancing.
    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/cpsr_flag_unit.md
CPSR_FLAG_UNIT -- requirements
Module: cpsr_flag_unit

Interface
REQ-001 SHALL provide ports, one per line as: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 StallE  input  1  Execute stage held; no state change.
REQ-005 FlushE  input  1  Execute instruction squashed.
REQ-006 CondE  input  4  ARM condition field of the Execute instruction.
REQ-007 FlagWriteE  input  2  S-bit enables: [1] updates N,Z; [0] updates C,V.
REQ-008 CVUpdateE  input  3  C/V source select from the ALU decoder.
REQ-009 ALUResultE  input  32  ALU result.
REQ-010 ALUCarryOutE, ALUOverflowE, ShifterCarryOutE  input  1 each  raw carry and overflow sources.
REQ-011 CPSRWriteE  input  1  MSR-style flag write; CPSRDataE  input  4  new NZCV.
REQ-012 MicroOpStartE, MicroOpLastE  input  1 each  micro-op sequence markers.
REQ-013 FlagsQ  output  4  committed architectural NZCV.
REQ-014 PreviousCVFlag  output  2  {C,V} of the visible flags, fed to the ALU decoder.
REQ-015 CondExE  output  1  Execute instruction passes its condition.
REQ-016 SeqActive  output  1  state is SEQ; SeqErr  output  1  one-cycle protocol-error pulse.

Function
REQ-017 Visible flags SHALL be the shadow NZCV in SEQ and FlagsQ in IDLE; CondExE and PreviousCVFlag SHALL be combinational from the visible flags.
REQ-018 CondExE SHALL decode CondE per ARMv4: 0000 EQ through 1101 LE, 1110 AL = 1, 1111 NV = 0.
REQ-019 An instruction is accepted when CondExE=1, StallE=0 and FlushE=0.
REQ-020 On an accepted instruction with FlagWriteE[1]=1: N = ALUResultE[31], Z = (ALUResultE == 0).
REQ-021 On an accepted instruction with FlagWriteE[0]=1, C and V SHALL be taken from CVUpdateE as follows:
- CVUpdateE[2]=1 (arithmetic): C = ALUCarryOutE, and V = ALUOverflowE unless CVUpdateE[1]=1 (KeepV), which retains V.
- CVUpdateE[2]=0 (logical): C = ShifterCarryOutE, V retained.
REQ-022 CPSRWriteE on an accepted instruction SHALL load NZCV = CPSRDataE and SHALL override FlagWriteE in the same cycle.
REQ-023 The state machine SHALL have two states, IDLE and SEQ; reset enters IDLE.
REQ-024 IDLE with accepted Start=1 and Last=0: enter SEQ, and the shadow SHALL load FlagsQ with this micro-op's update applied; FlagsQ is unchanged.
REQ-025 IDLE with Start=1 and Last=1, or with Start=0: a normal single op, and the update SHALL be written directly to FlagsQ.
REQ-026 In SEQ, an accepted non-Last micro-op SHALL update the shadow only.
REQ-027 In SEQ, an accepted Last micro-op SHALL make FlagsQ <= shadow with that micro-op's update applied, then return to IDLE.
REQ-028 In SEQ, a micro-op that fails its condition but is otherwise unstalled and unflushed SHALL still advance the sequence (Last still commits) without altering flags.
REQ-029 Start=1 while in SEQ SHALL pulse SeqErr for one cycle, and the micro-op SHALL be treated as a continuation.
REQ-030 FlushE=1 SHALL discard the shadow, leave FlagsQ unchanged and force IDLE; FlushE SHALL win over StallE.
REQ-031 StallE=1 without FlushE SHALL hold all state and suppress SeqErr.
REQ-032 Latency: a flag update SHALL be visible on CondExE and PreviousCVFlag in the cycle after acceptance; there is no same-cycle bypass.

Reset
REQ-033 When reset_n=0 at a clock edge: FlagsQ=0000, shadow=0000, state=IDLE, SeqActive=0, SeqErr=0.
REQ-034 Reset SHALL take priority over FlushE, StallE and all write inputs, including mid-sequence.

Verification
REQ-035 SUBS, CondE=1110, FlagWriteE=11, CVUpdateE=101, result 0x00000000, carry 1, overflow 0 -> next cycle FlagsQ=0110, PreviousCVFlag=10, CondE=0000 gives CondExE=1.
REQ-036 ADDS with CVUpdateE=110, prior V=1, result 0x80000000, carry 0, overflow 0 -> FlagsQ=1001 (KeepV holds V).
REQ-037 3-micro-op sequence (Start, middle, Last), each writing NZ from results 0x1, 0x0, 0xFFFFFFFF -> FlagsQ stays unchanged until the cycle after Last, then N=1, Z=0; SeqActive=1 for exactly 2 cycles.
REQ-038 FlushE asserted on the middle micro-op of a sequence started with FlagsQ=0010 -> SeqActive=0 next cycle, FlagsQ=0010, shadow discarded.
REQ-039 StallE=1 together with CPSRWriteE=1, CPSRDataE=1111 for 3 cycles, then StallE=0 -> FlagsQ changes only after the unstalled cycle, becoming 1111.
REQ-040 reset_n=0 while SEQ with FlagsQ=1111 -> next cycle FlagsQ=0000, SeqActive=0; CondE=0000 gives CondExE=0.
